adc78h90_scan: RTL

Free-running scan controller for the ADC78H90 12-bit housekeeping ADC. It drives the ADC's SPI pins (ADCCLK, nADCCS, ADCMOSI, ADCMISO) and cycles through channels 0..NCH-1. It publishes the latest 12-bit result per channel as a flat register bus with a one-cycle update strobe. It sits between the board ADC pins and the core's telemetry path (forward/reverse power, supply, temperature), clocked from IF_clk.

---
 rtl/adc78h90_scan.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/adc78h90_scan.sv
// adc78h90_scan: free-running channel scanner for the ADC78H90 12-bit SPI ADC.
// Each frame sends the next channel address on ADCMOSI and captures the result of the
// previous conversion from ADCMISO. The latest result per channel is published on ch_data.
// Optional build macro ADC78H90_AVG_EN turns each slot into a 4-sample exponential average.
module adc78h90_scan #(
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned NCH     = 4
) (
  input  logic              IF_clk,
  input  logic              IF_rst_n,
  input  logic              scan_en,
  output logic              ADCCLK,
  output logic              nADCCS,
  output logic              ADCMOSI,
  input  logic              ADCMISO,
  output logic [NCH*12-1:0] ch_data,
  output logic              ch_valid,
  output logic [2:0]        ch_idx
);

  localparam int unsigned CW = 9;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);
  localparam logic [2:0]    FIRST_ADD = (NCH == 1) ? 3'd0 : 3'd1;
  localparam logic [2:0]    LAST_CH   = 3'(NCH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4:0]          half_q, half_d;
  logic [15:0]         sr_q, sr_d;
  logic [11:0]         rx_q, rx_d;
  logic [2:0]          add_q, add_d;
  logic [2:0]          cur_ch_q, cur_ch_d;
  logic                discard_q, discard_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                mosi_q, mosi_d;
  logic [NCH*12-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [2:0]          idx_q, idx_d;
  logic [2:0]          nxt_ch_c;
`ifdef ADC78H90_AVG_EN
  logic [13:0]         acc_q [NCH];
  logic [13:0]         acc_d [NCH];
`endif

  // Channel following the one converted in the current frame (wraps at NCH).
  assign nxt_ch_c = (cur_ch_q == LAST_CH) ? 3'd0 : cur_ch_q + 3'd1;

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    sr_d      = sr_q;
    rx_d      = rx_q;
    add_d     = add_q;
    cur_ch_d  = cur_ch_q;
    discard_d = discard_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    idx_d     = idx_q;
`ifdef ADC78H90_AVG_EN
    acc_d     = acc_q;
`endif

    case (state_q)
      IDLE: begin
        sclk_d = 1'b1;
        cs_n_d = 1'b1;
        if (scan_en) begin
          state_d   = SETUP;
          cnt_d     = '0;
          cs_n_d    = 1'b0;
          discard_d = 1'b1;
          add_d     = FIRST_ADD;
          sr_d      = {2'b00, FIRST_ADD, 11'b0};
        end
      end

      SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          half_d  = '0;
          sclk_d  = 1'b0;
          mosi_d  = sr_q[15];
          sr_d    = {sr_q[14:0], 1'b0};
        end
      end

      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (half_q == 5'd31) begin
            state_d = HOLD;
          end else begin
            half_d = half_q + 5'd1;
            if (!sclk_q) begin
              sclk_d = 1'b1;
              rx_d   = {rx_q[10:0], ADCMISO};
            end else begin
              sclk_d = 1'b0;
              mosi_d = sr_q[15];
              sr_d   = {sr_q[14:0], 1'b0};
            end
          end
        end
      end

      HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          if (discard_q) begin
            discard_d = 1'b0;
            cur_ch_d  = add_q;
          end else begin
            valid_d  = 1'b1;
            idx_d    = cur_ch_q;
            cur_ch_d = nxt_ch_c;
            for (int unsigned k = 0; k < NCH; k++) begin
              if (cur_ch_q == 3'(k)) begin
`ifdef ADC78H90_AVG_EN
                acc_d[k] = acc_q[k] + 14'(rx_q) - (acc_q[k] >> 2);
                data_d[12*k +: 12] = acc_d[k][13:2];
`else
                data_d[12*k +: 12] = rx_q;
`endif
              end
            end
          end
        end
      end

      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (scan_en) begin
            state_d = SETUP;
            cs_n_d  = 1'b0;
            add_d   = nxt_ch_c;
            sr_d    = {2'b00, nxt_ch_c, 11'b0};
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset returns the pins to their idle levels at once.
  always_ff @(posedge IF_clk or negedge IF_rst_n) begin
    if (!IF_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      half_q    <= '0;
      sr_q      <= '0;
      rx_q      <= '0;
      add_q     <= '0;
      cur_ch_q  <= '0;
      discard_q <= 1'b0;
      sclk_q    <= 1'b1;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
`ifdef ADC78H90_AVG_EN
      for (int unsigned k = 0; k < NCH; k++) acc_q[k] <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      sr_q      <= sr_d;
      rx_q      <= rx_d;
      add_q     <= add_d;
      cur_ch_q  <= cur_ch_d;
      discard_q <= discard_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
`ifdef ADC78H90_AVG_EN
      acc_q     <= acc_d;
`endif
    end
  end

  assign ADCCLK   = sclk_q;
  assign nADCCS   = cs_n_q;
  assign ADCMOSI  = mosi_q;
  assign ch_data  = data_q;
  assign ch_valid = valid_q;
  assign ch_idx   = idx_q;

endmodule
